chip8_mem_arbiter: RTL and testbench

CHIP8_MEM_ARBITER -- requirements
Module: chip8_mem_arbiter

---
 rtl/chip8_mem_pkg.sv | 19 +
 rtl/mem_rr_pick.sv | 37 +++
 rtl/chip8_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_chip8_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_mem_pkg.sv
// rtl/chip8_mem_pkg.sv - shared types and defaults for the CHIP-8 RAM arbiter
package chip8_mem_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACK    = 2'd2,
    UPLOAD = 2'd3
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_BLT = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_rr_pick.sv
// rtl/mem_rr_pick.sv - two-way round-robin picker between CPU and blitter
module mem_rr_pick
  import chip8_mem_pkg::*;
(
  input  logic    clk,
  input  logic    res,
  input  logic    cpu_req,
  input  logic    blt_req,
  input  logic    take,
  output logic    any,
  output req_id_t pick
);

  req_id_t last;

  // remember the last granted requester; reset to blitter so the CPU wins the first tie
  always_ff @(posedge clk) begin
    if (res) begin
      last <= REQ_BLT;
    end else if (take) begin
      last <= pick;
    end
  end

  // a tie goes to whoever was not granted last
  always_comb begin
    any = cpu_req | blt_req;
    if (cpu_req && blt_req) begin
      pick = (last == REQ_BLT) ? REQ_CPU : REQ_BLT;
    end else if (blt_req) begin
      pick = REQ_BLT;
    end else begin
      pick = REQ_CPU;
    end
  end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// rtl/chip8_mem_arbiter.sv - single-port RAM arbiter for CPU, blitter and program upload
module chip8_mem_arbiter
  import chip8_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              res,
  input  logic              uploading,
  input  logic              up_we,
  input  logic [ADDR_W-1:0] up_a,
  input  logic [DATA_W-1:0] up_d,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_d,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_q,
  input  logic              blt_req,
  input  logic              blt_we,
  input  logic [ADDR_W-1:0] blt_a,
  input  logic [DATA_W-1:0] blt_d,
  output logic              blt_ack,
  output logic [DATA_W-1:0] blt_q,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q,
  output logic              up_overrun
);

  state_t            state, state_nx;
  req_id_t           gnt, pick;
  logic              any, start;
  logic              hold_full, hold_full_nx, hold_load, hold_drain, drop;
  logic [ADDR_W-1:0] hold_a;
  logic [DATA_W-1:0] hold_d;
  logic              we_raw;

  assign start = (state == IDLE) && !uploading && !hold_full && any;

  mem_rr_pick u_pick (
    .clk     (clk),
    .res     (res),
    .cpu_req (cpu_req),
    .blt_req (blt_req),
    .take    (start),
    .any     (any),
    .pick    (pick)
  );

  // hold buffer: a strobe outside UPLOAD is parked; in UPLOAD the parked entry drains and a new strobe may refill it
  always_comb begin
    hold_drain   = (state == UPLOAD) && hold_full;
    hold_load    = up_we && ((state == UPLOAD) ? hold_full : !hold_full);
    drop         = up_we && hold_full && (state != UPLOAD);
    hold_full_nx = hold_load ? 1'b1 : (hold_drain ? 1'b0 : hold_full);
  end

  // state, grant and hold-buffer registers
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      gnt       <= REQ_CPU;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nx;
      hold_full <= hold_full_nx;
      if (start) gnt <= pick;
    end
  end

  // hold buffer payload needs no reset; hold_full qualifies it
  always_ff @(posedge clk) begin
    if (hold_load) begin
      hold_a <= up_a;
      hold_d <= up_d;
    end
  end

  // next-state: upload has priority over arbitration, but an access in flight always finishes
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (uploading || hold_full) state_nx = UPLOAD;
        else if (any)               state_nx = GRANT;
      end
      GRANT:  state_nx = ACK;
      ACK:    state_nx = IDLE;
      UPLOAD: if (!uploading && !hold_full_nx) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // RAM port and ack outputs; writes are suppressed while reset is asserted
  always_comb begin
    ram_a  = '0;
    ram_d  = '0;
    we_raw = 1'b0;
    case (state)
      GRANT: begin
        ram_a  = (gnt == REQ_CPU) ? cpu_a  : blt_a;
        ram_d  = (gnt == REQ_CPU) ? cpu_d  : blt_d;
        we_raw = (gnt == REQ_CPU) ? cpu_we : blt_we;
      end
      UPLOAD: begin
        if (hold_full) begin
          ram_a  = hold_a;
          ram_d  = hold_d;
          we_raw = 1'b1;
        end else if (up_we) begin
          ram_a  = up_a;
          ram_d  = up_d;
          we_raw = 1'b1;
        end
      end
      default: ;
    endcase
    ram_we  = we_raw & ~res;
    cpu_ack = (state == ACK) && (gnt == REQ_CPU) && !res;
    blt_ack = (state == ACK) && (gnt == REQ_BLT) && !res;
  end

  // read-data holding registers and sticky overrun flag
  always_ff @(posedge clk) begin
    if (res) begin
      cpu_q      <= '0;
      blt_q      <= '0;
      up_overrun <= 1'b0;
    end else begin
      if (cpu_ack) cpu_q <= ram_q;
      if (blt_ack) blt_q <= ram_q;
      if (drop)    up_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb/tb_chip8_mem_arbiter.sv - self-checking bench for chip8_mem_arbiter
module tb_chip8_mem_arbiter;

  logic        clk = 1'b0;
  logic        res, uploading, up_we, cpu_req, cpu_we, blt_req, blt_we;
  logic [11:0] up_a, cpu_a, blt_a, ram_a;
  logic [7:0]  up_d, cpu_d, blt_d, ram_d, ram_q, cpu_q, blt_q;
  logic        cpu_ack, blt_ack, ram_we, up_overrun;

  logic        clr, pre_we, exp_drop;
  logic [11:0] pre_a;
  logic [7:0]  pre_d;
  logic [7:0]  mem    [0:4095];
  logic [7:0]  shadow [0:4095];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk(clk), .res(res), .uploading(uploading),
    .up_we(up_we), .up_a(up_a), .up_d(up_d),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_ack(cpu_ack), .cpu_q(cpu_q),
    .blt_req(blt_req), .blt_we(blt_we), .blt_a(blt_a), .blt_d(blt_d),
    .blt_ack(blt_ack), .blt_q(blt_q),
    .ram_a(ram_a), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q),
    .up_overrun(up_overrun)
  );

  // read-first single-port RAM with bench-side clear and preload
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else if (ram_we) begin
      mem[ram_a] <= ram_d;
    end
    ram_q <= mem[ram_a];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic wait_ack(input bit blt, input int max, output bit ok, output int n);
    ok = 1'b0; n = 0;
    while (!ok && n < max) begin
      @(negedge clk);
      n++;
      if (blt ? blt_ack : cpu_ack) ok = 1'b1;
    end
  endtask

  // Model: every accepted write lands in shadow; an ack returns the pre-access content of the
  // addressed word and the port's q then holds it until that port's next ack.
  initial begin
    logic [7:0] exp_cpu_q, exp_blt_q;
    exp_cpu_q = 8'h00;
    exp_blt_q = 8'h00;
    forever begin
      @(negedge clk);
      if (res) begin
        exp_cpu_q = 8'h00;
        exp_blt_q = 8'h00;
        chk("ram_we_in_res", ram_we, 1'b0);
      end else begin
        chk("ack_overlap", cpu_ack & blt_ack, 1'b0);
        chk("cpu_q_model", cpu_q, exp_cpu_q);
        chk("blt_q_model", blt_q, exp_blt_q);
        if (cpu_ack) begin
          chk("cpu_ack_without_req", cpu_req, 1'b1);
          exp_cpu_q = shadow[cpu_a];
          if (cpu_we) shadow[cpu_a] = cpu_d;
        end
        if (blt_ack) begin
          chk("blt_ack_without_req", blt_req, 1'b1);
          exp_blt_q = shadow[blt_a];
          if (blt_we) shadow[blt_a] = blt_d;
        end
      end
      if (clr) for (int i = 0; i < 4096; i++) shadow[i] = 8'h00;
      if (pre_we) shadow[pre_a] = pre_d;
      if (up_we && !exp_drop && !res) shadow[up_a] = up_d;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    int order[$];
    int ack_cyc[$];

    res = 1'b1; uploading = 1'b0; up_we = 1'b0; up_a = '0; up_d = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_d = '0;
    blt_req = 1'b0; blt_we = 1'b0; blt_a = '0; blt_d = '0;
    clr = 1'b0; pre_we = 1'b0; pre_a = '0; pre_d = '0; exp_drop = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_blt_ack", blt_ack, 1'b0);
    chk("rst_cpu_q", cpu_q, 8'h00);
    chk("rst_blt_q", blt_q, 8'h00);
    chk("rst_overrun", up_overrun, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    #1;
    clr = 1'b1;
    @(negedge clk); #1;
    clr = 1'b0;
    preload(12'h200, 8'hA2);
    preload(12'h010, 8'h31);
    preload(12'h020, 8'h42);
    preload(12'h211, 8'h5A);
    preload(12'h300, 8'h99);
    res = 1'b0;
    @(negedge clk); #1;

    // tie after reset: CPU write 0x3C to 0x010, blitter read 0x020, both held
    cpu_we = 1'b1; cpu_a = 12'h010; cpu_d = 8'h3C; cpu_req = 1'b1;
    blt_we = 1'b0; blt_a = 12'h020; blt_req = 1'b1;
    for (int k = 1; k <= 20 && order.size() < 4; k++) begin
      @(negedge clk);
      if (cpu_ack) begin order.push_back(0); ack_cyc.push_back(k); end
      if (blt_ack) begin order.push_back(1); ack_cyc.push_back(k); end
      #1;
      if (order.size() == 3) cpu_req = 1'b0;
      if (order.size() == 4) blt_req = 1'b0;
    end
    cpu_req = 1'b0; blt_req = 1'b0;
    chk("tie_ack_count", order.size(), 4);
    if (order.size() == 4) begin
      chk("tie_order0", order[0], 0);
      chk("tie_order1", order[1], 1);
      chk("tie_order2", order[2], 0);
      chk("tie_order3", order[3], 1);
      chk("tie_first_latency", ack_cyc[0], 2);
      chk("tie_spacing", ack_cyc[1], 5);
    end
    @(negedge clk);
    chk("tie_cpu_q", cpu_q, 8'h3C);
    chk("tie_blt_q", blt_q, 8'h42);
    #1;

    // CPU read alone from 0x200
    cpu_we = 1'b0; cpu_a = 12'h200; cpu_req = 1'b1;
    @(negedge clk);
    chk("rd_ram_a", ram_a, 12'h200);
    chk("rd_ram_we", ram_we, 1'b0);
    chk("rd_ack_early", cpu_ack, 1'b0);
    @(negedge clk);
    chk("rd_ack", cpu_ack, 1'b1);
    #1; cpu_req = 1'b0;
    @(negedge clk);
    chk("rd_ack_pulse", cpu_ack, 1'b0);
    chk("rd_q", cpu_q, 8'hA2);
    repeat (4) @(negedge clk);
    chk("rd_q_hold", cpu_q, 8'hA2);
    #1;

    // upload 16 bytes with a CPU read queued behind it
    uploading = 1'b1;
    @(negedge clk); #1;
    cpu_we = 1'b0; cpu_a = 12'h205; cpu_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      up_we = 1'b1; up_a = 12'h200 + 12'(i); up_d = 8'(i);
      @(negedge clk);
      chk("up_cpu_held", cpu_ack, 1'b0);
      #1;
    end
    up_we = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("up_cpu_held_idle", cpu_ack, 1'b0);
    end
    #1; uploading = 1'b0;
    wait_ack(1'b0, 10, ok, n);
    chk("up_cpu_ack", ok, 1'b1);
    chk("up_cpu_latency", n, 3);
    #1; cpu_req = 1'b0;
    @(negedge clk);
    chk("up_cpu_q", cpu_q, 8'h05);
    chk("up_overrun_clear", up_overrun, 1'b0);
    chk("up_mem_205", mem[12'h205], 8'h05);
    chk("up_mem_20f", mem[12'h20F], 8'h0F);
    #1;

    // strobe during blitter ACK is held, the next one is dropped
    blt_we = 1'b0; blt_a = 12'h020; blt_req = 1'b1;
    wait_ack(1'b1, 10, ok, n);
    chk("ovr_blt_ack", ok, 1'b1);
    chk("ovr_blt_latency", n, 2);
    #1; blt_req = 1'b0;
    up_we = 1'b1; up_a = 12'h210; up_d = 8'h77;
    @(negedge clk); #1;
    up_a = 12'h211; up_d = 8'h88; exp_drop = 1'b1;
    @(negedge clk);
    chk("ovr_flag", up_overrun, 1'b1);
    #1; up_we = 1'b0; exp_drop = 1'b0;
    repeat (4) @(negedge clk);
    chk("ovr_sticky", up_overrun, 1'b1);
    chk("ovr_blt_q", blt_q, 8'h42);
    chk("ovr_mem_210", mem[12'h210], 8'h77);
    chk("ovr_mem_211", mem[12'h211], 8'h5A);
    #1;

    // reset during GRANT of a CPU write aborts it
    cpu_we = 1'b1; cpu_a = 12'h300; cpu_d = 8'h55; cpu_req = 1'b1;
    @(negedge clk);
    chk("abort_in_grant", ram_we, 1'b1);
    chk("abort_grant_a", ram_a, 12'h300);
    #1; res = 1'b1;
    @(negedge clk);
    chk("abort_cpu_ack", cpu_ack, 1'b0);
    chk("abort_blt_ack", blt_ack, 1'b0);
    chk("abort_cpu_q", cpu_q, 8'h00);
    chk("abort_blt_q", blt_q, 8'h00);
    chk("abort_overrun", up_overrun, 1'b0);
    chk("abort_ram_we", ram_we, 1'b0);
    #1; cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk); #1;
    res = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_ack", cpu_ack, 1'b0);
    end
    chk("abort_mem_300", mem[12'h300], 8'h99);
    chk("abort_mem_010", mem[12'h010], 8'h3C);

    // final RAM image against the model
    for (int i = 0; i < 16; i++) begin
      chk("ram_image", {20'h0, mem[12'h200 + 12'(i)]}, {20'h0, shadow[12'h200 + 12'(i)]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
